// File: rtl/helppll_loopfilter.sv
// Helper-PLL PI loop filter: frequency error -> saturated signed DAC tuning word, plus lock FSM.
// Latency: 3 cycles from stb_freqdiff to stb_tune/tune/locked/state/sat.
// Backpressure: none; strobes arriving while S1 or S2 is busy are dropped and flagged in sticky overrun.
module helppll_loopfilter #(
    parameter int DWIDTH  = 32,
    parameter int OWIDTH  = 16,
    parameter int AWIDTH  = 40,
    parameter int LOCKTOL = 4,
    parameter int LOCKCNT = 8
) (
    input  logic                     clk,
    input  logic                     areset,
    input  logic                     enable,
    input  logic signed [DWIDTH-1:0] freqdiff,
    input  logic                     stb_freqdiff,
    input  logic [4:0]               kp_shift,
    input  logic [4:0]               ki_shift,
    input  logic signed [OWIDTH-1:0] tune_init,
    output logic signed [OWIDTH-1:0] tune,
    output logic                     stb_tune,
    output logic                     locked,
    output logic [1:0]               state,
    output logic                     sat,
    output logic                     overrun
);

    localparam int CW  = $clog2(LOCKCNT + 1);
    localparam int AW1 = AWIDTH + 1;
    localparam int SW  = AWIDTH + 2;

    localparam logic signed [DWIDTH-1:0] DMIN = {1'b1, {(DWIDTH-1){1'b0}}};
    localparam logic signed [DWIDTH-1:0] DMAX = {1'b0, {(DWIDTH-1){1'b1}}};
    localparam logic signed [AWIDTH-1:0] AMIN = {1'b1, {(AWIDTH-1){1'b0}}};
    localparam logic signed [AWIDTH-1:0] AMAX = {1'b0, {(AWIDTH-1){1'b1}}};
    localparam logic signed [OWIDTH-1:0] OMIN = {1'b1, {(OWIDTH-1){1'b0}}};
    localparam logic signed [OWIDTH-1:0] OMAX = {1'b0, {(OWIDTH-1){1'b1}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACQ  = 2'd1,
        ST_LOCK = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [CW-1:0]              lockcnt_q, lockcnt_d;
    logic                       s1_vld_q, s1_vld_d;
    logic                       s2_vld_q, s2_vld_d;
    logic signed [DWIDTH-1:0]   err_q, err_d;
    logic [DWIDTH-1:0]          abserr_q, abserr_d;
    logic [DWIDTH-1:0]          abserr2_q, abserr2_d;
    logic signed [DWIDTH-1:0]   p_q, p_d;
    logic signed [AWIDTH-1:0]   integ_q, integ_d;
    logic signed [OWIDTH-1:0]   tune_q, tune_d;
    logic                       stb_tune_q, stb_tune_d;
    logic                       sat_q, sat_d;
    logic                       sat_hi_q, sat_hi_d;
    logic                       sat_lo_q, sat_lo_d;
    logic                       locked_q, locked_d;
    logic                       overrun_q, overrun_d;

    logic                       run;
    logic                       busy;
    logic signed [DWIDTH-1:0]   neg_fd;
    logic signed [DWIDTH-1:0]   p_w;
    logic signed [DWIDTH-1:0]   di;
    logic signed [AWIDTH:0]     isum;
    logic signed [AWIDTH-1:0]   isat;
    logic                       windup;
    logic signed [SW-1:0]       sum;
    logic                       clamp_hi;
    logic                       clamp_lo;
    logic signed [OWIDTH-1:0]   tune_clamped;
    logic [CW-1:0]              cnt_inc;

    // Datapath arithmetic: error negation, gain shifts, integrator and output clamps
    always_comb begin
        // -MIN does not fit, so it saturates to +MAX; |freqdiff| shares the same path
        neg_fd   = (freqdiff == DMIN) ? DMAX : -freqdiff;
        abserr_d = freqdiff[DWIDTH-1] ? neg_fd : freqdiff;
        err_d    = neg_fd;

        // Gains sampled as S2 consumes the error
        p_w = err_q >>> kp_shift;
        di  = err_q >>> ki_shift;

        isum = AW1'(integ_q) + AW1'(di);
        if (isum[AWIDTH] != isum[AWIDTH-1]) begin
            isat = isum[AWIDTH] ? AMIN : AMAX;
        end else begin
            isat = isum[AWIDTH-1:0];
        end

        // Do not push the integrator further into a clamp the output is already in
        windup = (sat_hi_q && !di[DWIDTH-1] && (di != '0)) || (sat_lo_q && di[DWIDTH-1]);

        sum      = SW'(tune_init) + SW'(p_q) + SW'(integ_q);
        clamp_hi = !sum[SW-1] && (|sum[SW-2:OWIDTH-1]);
        clamp_lo = sum[SW-1] && !(&sum[SW-2:OWIDTH-1]);
        if (clamp_hi) begin
            tune_clamped = OMAX;
        end else if (clamp_lo) begin
            tune_clamped = OMIN;
        end else begin
            tune_clamped = sum[OWIDTH-1:0];
        end
    end

    // Next-state: pipeline valids, integrator, output register, lock FSM and overrun
    always_comb begin
        run  = enable && (state_q != ST_IDLE);
        busy = s1_vld_q || s2_vld_q;

        s1_vld_d   = run && stb_freqdiff && !busy;
        s2_vld_d   = run && s1_vld_q;
        abserr2_d  = s1_vld_q ? abserr_q : abserr2_q;
        p_d        = s1_vld_q ? p_w : p_q;
        integ_d    = integ_q;
        tune_d     = tune_q;
        stb_tune_d = 1'b0;
        sat_d      = sat_q;
        sat_hi_d   = sat_hi_q;
        sat_lo_d   = sat_lo_q;
        state_d    = state_q;
        lockcnt_d  = lockcnt_q;
        overrun_d  = overrun_q;
        cnt_inc    = lockcnt_q + 1'b1;

        if (!run) begin
            integ_d   = '0;
            tune_d    = tune_init;
            sat_d     = 1'b0;
            sat_hi_d  = 1'b0;
            sat_lo_d  = 1'b0;
            lockcnt_d = '0;
        end else begin
            if (s1_vld_q && !windup) begin
                integ_d = isat;
            end
            if (s2_vld_q) begin
                tune_d     = tune_clamped;
                stb_tune_d = 1'b1;
                sat_d      = clamp_hi || clamp_lo;
                sat_hi_d   = clamp_hi;
                sat_lo_d   = clamp_lo;
                if (state_q == ST_ACQ) begin
                    if (abserr2_q <= DWIDTH'(LOCKTOL)) begin
                        lockcnt_d = cnt_inc;
                        if (cnt_inc == CW'(LOCKCNT)) begin
                            state_d = ST_LOCK;
                        end
                    end else begin
                        lockcnt_d = '0;
                    end
                end else if (abserr2_q > DWIDTH'(2 * LOCKTOL)) begin
                    state_d   = ST_ACQ;
                    lockcnt_d = '0;
                end
            end
        end

        if (!enable) begin
            state_d   = ST_IDLE;
            overrun_d = 1'b0;
        end else begin
            if (state_q == ST_IDLE) begin
                state_d = ST_ACQ;
            end
            if (run && stb_freqdiff && busy) begin
                overrun_d = 1'b1;
            end
        end

        locked_d = (state_d == ST_LOCK);
    end

    // All state registers; asynchronous reset returns the block to a quiet IDLE
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q    <= ST_IDLE;
            lockcnt_q  <= '0;
            s1_vld_q   <= 1'b0;
            s2_vld_q   <= 1'b0;
            err_q      <= '0;
            abserr_q   <= '0;
            abserr2_q  <= '0;
            p_q        <= '0;
            integ_q    <= '0;
            tune_q     <= '0;
            stb_tune_q <= 1'b0;
            sat_q      <= 1'b0;
            sat_hi_q   <= 1'b0;
            sat_lo_q   <= 1'b0;
            locked_q   <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lockcnt_q  <= lockcnt_d;
            s1_vld_q   <= s1_vld_d;
            s2_vld_q   <= s2_vld_d;
            if (s1_vld_d) begin
                err_q    <= err_d;
                abserr_q <= abserr_d;
            end
            abserr2_q  <= abserr2_d;
            p_q        <= p_d;
            integ_q    <= integ_d;
            tune_q     <= tune_d;
            stb_tune_q <= stb_tune_d;
            sat_q      <= sat_d;
            sat_hi_q   <= sat_hi_d;
            sat_lo_q   <= sat_lo_d;
            locked_q   <= locked_d;
            overrun_q  <= overrun_d;
        end
    end

    assign tune     = tune_q;
    assign stb_tune = stb_tune_q;
    assign locked   = locked_q;
    assign state    = state_q;
    assign sat      = sat_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_helppll_loopfilter.sv
// Scoreboard bench for helppll_loopfilter: stimulus pushes expected outputs, monitor pops on stb_tune.
// Latency: each expectation carries the cycle its stb_tune must appear in (strobe + 3).
// Backpressure: stimulus keeps strobe spacing itself except where dropping is the point.
module tb_helppll_loopfilter;

    logic               clk = 1'b0;
    logic               areset;
    logic               enable;
    logic signed [31:0] freqdiff;
    logic               stb_freqdiff;
    logic [4:0]         kp_shift;
    logic [4:0]         ki_shift;
    logic signed [15:0] tune_init;
    logic signed [15:0] tune;
    logic               stb_tune;
    logic               locked;
    logic [1:0]         state;
    logic               sat;
    logic               overrun;

    int ncmp  = 0;
    int nfail = 0;
    int cyc   = 0;

    typedef struct {
        logic signed [15:0] tune;
        logic               sat;
        logic               locked;
        logic [1:0]         state;
        int                 cyc;
    } exp_t;

    exp_t sb[$];

    helppll_loopfilter dut (
        .clk          (clk),
        .areset       (areset),
        .enable       (enable),
        .freqdiff     (freqdiff),
        .stb_freqdiff (stb_freqdiff),
        .kp_shift     (kp_shift),
        .ki_shift     (ki_shift),
        .tune_init    (tune_init),
        .tune         (tune),
        .stb_tune     (stb_tune),
        .locked       (locked),
        .state        (state),
        .sat          (sat),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) tick();
    endtask

    // Issue one strobe and register what the DUT must present three cycles later
    task automatic strobe(input logic signed [31:0] fd, input logic signed [15:0] et,
                          input logic es, input logic el, input logic [1:0] est);
        exp_t e;
        e.tune   = et;
        e.sat    = es;
        e.locked = el;
        e.state  = est;
        e.cyc    = cyc + 3;
        sb.push_back(e);
        freqdiff     = fd;
        stb_freqdiff = 1'b1;
        tick();
        stb_freqdiff = 1'b0;
    endtask

    // Strobe that must not produce any output
    task automatic strobe_silent(input logic signed [31:0] fd);
        freqdiff     = fd;
        stb_freqdiff = 1'b1;
        tick();
        stb_freqdiff = 1'b0;
    endtask

    // Pass through IDLE (clears integrator, lock count, overrun) and re-enter ACQUIRE
    task automatic restart();
        enable = 1'b0;
        wait_cyc(3);
        enable = 1'b1;
        wait_cyc(3);
    endtask

    // Monitor: every stb_tune must match the oldest pending expectation
    always @(negedge clk) begin
        if (!areset && stb_tune) begin
            if (sb.size() == 0) begin
                check("unexpected_stb_tune", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("tune",         tune,   e.tune);
                check("sat",          sat,    e.sat);
                check("locked",       locked, e.locked);
                check("state",        state,  e.state);
                check("stb_latency",  cyc,    e.cyc);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, pending=%0d", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        areset       = 1'b1;
        enable       = 1'b0;
        freqdiff     = '0;
        stb_freqdiff = 1'b0;
        kp_shift     = 5'd0;
        ki_shift     = 5'd31;
        tune_init    = 16'sd1000;

        // Reset values, then IDLE tracking of tune_init with one register delay
        wait_cyc(3);
        check("rst_tune",    tune,     0);
        check("rst_stb",     stb_tune, 0);
        check("rst_locked",  locked,   0);
        check("rst_state",   state,    0);
        check("rst_sat",     sat,      0);
        check("rst_overrun", overrun,  0);
        areset = 1'b0;
        #1;
        check("idle_tune_before_edge", tune, 0);
        tick();
        check("idle_tune_tracks", tune, 1000);
        tune_init = 16'sd1234;
        tick();
        check("idle_tune_follow", tune, 1234);
        strobe_silent(32'sd77);
        wait_cyc(5);
        check("idle_no_overrun", overrun, 0);
        check("idle_state", state, 0);

        // Proportional step. ki_shift=31 still leaves -1 in the integrator for a
        // negative error (arithmetic shift floors), so 50 yields -50 + -1 = -51.
        tune_init = 16'sd0;
        kp_shift  = 5'd0;
        ki_shift  = 5'd31;
        restart();
        check("acq_state", state, 1);
        strobe(32'sd50, -16'sd51, 1'b0, 1'b0, 2'd1);
        wait_cyc(9);
        // Positive error: p=+50, di=0, integrator stays at -1
        strobe(-32'sd50, 16'sd49, 1'b0, 1'b0, 2'd1);
        wait_cyc(9);

        // Pure integration of err=+3 and lock after 8 in-tolerance strobes
        kp_shift = 5'd31;
        ki_shift = 5'd0;
        restart();
        for (int i = 1; i <= 8; i++) begin
            strobe(-32'sd3, 16'(3 * i), 1'b0, (i == 8), (i == 8) ? 2'd2 : 2'd1);
            wait_cyc(9);
        end
        // |9| > 2*LOCKTOL drops lock; p = -9>>>31 = -1, integ = 24-9 = 15
        strobe(32'sd9, 16'sd14, 1'b0, 1'b0, 2'd1);
        wait_cyc(9);

        // Saturation with anti-windup: di = (2^31-1)>>>16 = 32767 enters once
        kp_shift  = 5'd0;
        ki_shift  = 5'd16;
        tune_init = 16'sd0;
        restart();
        for (int i = 0; i < 5; i++) begin
            strobe(32'h8000_0000, 16'sd32767, 1'b1, 1'b0, 2'd1);
            wait_cyc(9);
        end
        // p=-100, di=-1 allowed out of the high clamp: 32767-1-100 = 32666
        strobe(32'sd100, 16'sd32666, 1'b0, 1'b0, 2'd1);
        wait_cyc(9);

        // Overrun: second strobe one cycle later is dropped
        kp_shift = 5'd0;
        ki_shift = 5'd31;
        restart();
        check("ovr_clear_before", overrun, 0);
        strobe(-32'sd20, 16'sd20, 1'b0, 1'b0, 2'd1);
        strobe_silent(32'sd7);
        check("ovr_set", overrun, 1);
        wait_cyc(8);
        check("ovr_sticky", overrun, 1);
        enable = 1'b0;
        wait_cyc(2);
        check("ovr_cleared_by_enable", overrun, 0);

        // Abort: enable falls the cycle after a strobe; nothing may come out
        tune_init = 16'sd777;
        ki_shift  = 5'd0;
        restart();
        freqdiff     = -32'sd40;
        stb_freqdiff = 1'b1;
        tick();
        stb_freqdiff = 1'b0;
        enable       = 1'b0;
        tick();
        check("abort_state", state, 0);
        check("abort_integ", dut.integ_q, 0);
        check("abort_tune",  tune, 777);
        wait_cyc(6);
        check("abort_tune_hold", tune, 777);

        // Reset in the middle of a strobe: immediate clear, no stb_tune
        restart();
        strobe_silent(-32'sd40);
        areset = 1'b1;
        #1;
        check("midrst_tune",  tune,  0);
        check("midrst_state", state, 0);
        wait_cyc(2);
        areset = 1'b0;
        wait_cyc(6);

        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
